// File: rtl/axis_pkt_gen_if.sv
// AXI4-Stream bundle between the packet generator (master) and its sink (slave).
interface axis_pkt_gen_if #(
    parameter int TDATA_WIDTH = 64
);
    localparam int BYTES = TDATA_WIDTH / 8;

    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic [BYTES-1:0]       tkeep;
    logic                   tlast;

    modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream burst generator: pkt_num packets of pkt_len bytes carrying a byte ramp,
// separated by gap_cycles idle cycles, with graceful stop and full backpressure support.
module axis_pkt_gen #(
    parameter int TDATA_WIDTH = 64,
    parameter int LEN_WIDTH   = 16,
    parameter int GAP_WIDTH   = 8
) (
    input  logic                 m_aclk,
    input  logic                 m_aresetn,
    input  logic                 start,
    input  logic                 stop,
    input  logic [LEN_WIDTH-1:0] pkt_len,
    input  logic [15:0]          pkt_num,
    input  logic [GAP_WIDTH-1:0] gap_cycles,
    axis_pkt_gen_if.master       m_axis,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          pkt_cnt
);
    localparam int                   BYTES    = TDATA_WIDTH / 8;
    localparam logic [7:0]           BYTES8   = 8'(BYTES);
    localparam logic [LEN_WIDTH-1:0] BYTES_L  = LEN_WIDTH'(BYTES);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = LEN_WIDTH'(0);
    localparam logic [GAP_WIDTH-1:0] GAP_ONE  = GAP_WIDTH'(1);
    localparam logic [GAP_WIDTH-1:0] GAP_ZERO = GAP_WIDTH'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    // Keep mask of the final beat: low (len mod BYTES) lanes, or all lanes on an exact fit.
    function automatic logic [BYTES-1:0] last_keep(input logic [LEN_WIDTH-1:0] len);
        logic [LEN_WIDTH-1:0] rem;
        logic [BYTES-1:0]     keep;
        rem = len % BYTES_L;
        for (int k = 0; k < BYTES; k++) begin
            keep[k] = (rem == LEN_ZERO) || (LEN_WIDTH'(k) < rem);
        end
        return keep;
    endfunction

    function automatic logic [TDATA_WIDTH-1:0] ramp_data(input logic [7:0] base,
                                                         input logic [BYTES-1:0] keep);
        logic [TDATA_WIDTH-1:0] data;
        for (int k = 0; k < BYTES; k++) begin
            data[8*k +: 8] = keep[k] ? (base + 8'(k)) : 8'd0;
        end
        return data;
    endfunction

    state_t                 r_state, w_state;
    logic [15:0]            r_num, w_num;
    logic [GAP_WIDTH-1:0]   r_gap, w_gap, r_gap_cnt, w_gap_cnt;
    logic [LEN_WIDTH-1:0]   r_last_idx, w_last_idx, r_beat, w_beat;
    logic [BYTES-1:0]       r_last_keep, w_last_keep;
    logic [15:0]            r_pkt_cnt, w_pkt_cnt;
    logic                   r_stop_pend, w_stop_pend;
    logic                   r_tvalid, w_tvalid, r_tlast, r_busy, w_busy, r_done, w_done;
    logic [TDATA_WIDTH-1:0] r_tdata;
    logic [BYTES-1:0]       r_tkeep;

    logic                   w_load;
    logic [7:0]             w_sel_pkt;
    logic [LEN_WIDTH-1:0]   w_sel_beat, w_sel_last_idx;
    logic [BYTES-1:0]       w_sel_last_keep;
    logic [LEN_WIDTH-1:0]   w_in_last_idx;
    logic [BYTES-1:0]       w_in_last_keep;
    logic                   w_beat_last;
    logic [BYTES-1:0]       w_beat_keep;
    logic [7:0]             w_beat_base;
    logic [TDATA_WIDTH-1:0] w_beat_data;
    logic [15:0]            w_cnt_inc;
    logic                   w_accept, w_stop;

    assign w_in_last_idx  = (pkt_len - LEN_ONE) / BYTES_L;
    assign w_in_last_keep = last_keep(pkt_len);
    assign w_cnt_inc      = r_pkt_cnt + 16'd1;
    assign w_accept       = r_tvalid & m_axis.tready;
    assign w_stop         = r_stop_pend | stop;

    // The beat selected by the FSM is formatted here and captured only when w_load is set.
    assign w_beat_last = (w_sel_beat == w_sel_last_idx);
    assign w_beat_keep = w_beat_last ? w_sel_last_keep : {BYTES{1'b1}};
    assign w_beat_base = w_sel_pkt + (8'(w_sel_beat) * BYTES8);
    assign w_beat_data = ramp_data(w_beat_base, w_beat_keep);

    // Next-state and next-output decode; everything holds unless a branch overrides it.
    always_comb begin
        w_state         = r_state;
        w_num           = r_num;
        w_gap           = r_gap;
        w_gap_cnt       = r_gap_cnt;
        w_last_idx      = r_last_idx;
        w_last_keep     = r_last_keep;
        w_beat          = r_beat;
        w_pkt_cnt       = r_pkt_cnt;
        w_stop_pend     = r_stop_pend | (r_busy & stop);
        w_tvalid        = r_tvalid;
        w_busy          = r_busy;
        w_done          = 1'b0;
        w_load          = 1'b0;
        w_sel_pkt       = r_pkt_cnt[7:0];
        w_sel_beat      = r_beat;
        w_sel_last_idx  = r_last_idx;
        w_sel_last_keep = r_last_keep;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_num       = pkt_num;
                    w_gap       = gap_cycles;
                    w_last_idx  = w_in_last_idx;
                    w_last_keep = w_in_last_keep;
                    w_beat      = LEN_ZERO;
                    w_pkt_cnt   = 16'd0;
                    w_stop_pend = 1'b0;
                    if ((pkt_len != LEN_ZERO) && (pkt_num != 16'd0)) begin
                        w_state         = ST_SEND;
                        w_busy          = 1'b1;
                        w_tvalid        = 1'b1;
                        w_load          = 1'b1;
                        w_sel_pkt       = 8'd0;
                        w_sel_beat      = LEN_ZERO;
                        w_sel_last_idx  = w_in_last_idx;
                        w_sel_last_keep = w_in_last_keep;
                    end else begin
                        w_state = ST_FIN;
                        w_done  = 1'b1;
                    end
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (w_accept && r_tlast) begin
                    w_pkt_cnt = w_cnt_inc;
                    if ((w_cnt_inc == r_num) || w_stop) begin
                        w_state  = ST_FIN;
                        w_done   = 1'b1;
                        w_busy   = 1'b0;
                        w_tvalid = 1'b0;
                    end else if (r_gap != GAP_ZERO) begin
                        w_state   = ST_GAP;
                        w_gap_cnt = r_gap;
                        w_tvalid  = 1'b0;
                    end else begin
                        w_beat     = LEN_ZERO;
                        w_load     = 1'b1;
                        w_sel_pkt  = w_cnt_inc[7:0];
                        w_sel_beat = LEN_ZERO;
                    end
                end else if (w_accept) begin
                    w_beat     = r_beat + LEN_ONE;
                    w_load     = 1'b1;
                    w_sel_beat = r_beat + LEN_ONE;
                end else begin
                    w_state = ST_SEND;
                end
            end
            ST_GAP: begin
                if (w_stop) begin
                    w_state = ST_FIN;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                end else if (r_gap_cnt == GAP_ONE) begin
                    w_state    = ST_SEND;
                    w_tvalid   = 1'b1;
                    w_beat     = LEN_ZERO;
                    w_load     = 1'b1;
                    w_sel_beat = LEN_ZERO;
                end else begin
                    w_gap_cnt = r_gap_cnt - GAP_ONE;
                end
            end
            ST_FIN: begin
                w_state     = ST_IDLE;
                w_busy      = 1'b0;
                w_stop_pend = 1'b0;
            end
            default: begin
                w_state  = ST_IDLE;
                w_tvalid = 1'b0;
                w_busy   = 1'b0;
            end
        endcase
    end

    // State and output registers; the beat payload changes only when a new beat is loaded.
    always_ff @(posedge m_aclk or negedge m_aresetn) begin
        if (!m_aresetn) begin
            r_state     <= ST_IDLE;
            r_num       <= 16'd0;
            r_gap       <= GAP_ZERO;
            r_gap_cnt   <= GAP_ZERO;
            r_last_idx  <= LEN_ZERO;
            r_last_keep <= {BYTES{1'b0}};
            r_beat      <= LEN_ZERO;
            r_pkt_cnt   <= 16'd0;
            r_stop_pend <= 1'b0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tdata     <= {TDATA_WIDTH{1'b0}};
            r_tkeep     <= {BYTES{1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_num       <= w_num;
            r_gap       <= w_gap;
            r_gap_cnt   <= w_gap_cnt;
            r_last_idx  <= w_last_idx;
            r_last_keep <= w_last_keep;
            r_beat      <= w_beat;
            r_pkt_cnt   <= w_pkt_cnt;
            r_stop_pend <= w_stop_pend;
            r_tvalid    <= w_tvalid;
            r_busy      <= w_busy;
            r_done      <= w_done;
            if (w_load) begin
                r_tdata <= w_beat_data;
                r_tkeep <= w_beat_keep;
                r_tlast <= w_beat_last;
            end
        end
    end

    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tdata  = r_tdata;
    assign m_axis.tkeep  = r_tkeep;
    assign m_axis.tlast  = r_tlast;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pkt_cnt       = r_pkt_cnt;
endmodule
